// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Shares a single byte-address/byte-data i2c_master between NUM_REQ init
// sequencers. Each requester holds req_valid with its transaction fields until
// it sees its one-cycle req_done. Ownership rotates round-robin, starting just
// after the previous owner. The arbiter latches the winner's fields, issues one
// command pulse to the master and waits for m_done. If m_done never arrives,
// a watchdog returns status 3'b111 instead.

module i2c_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_rw,
   input  logic [7*NUM_REQ-1:0] req_chip_addr,
   input  logic [8*NUM_REQ-1:0] req_reg_addr,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   req_done,
   output logic [7:0]           req_rdata,
   output logic [2:0]           req_status,
   output logic [6:0]           m_chip_addr,
   output logic [7:0]           m_reg_addr,
   output logic [7:0]           m_data_in,
   output logic                 m_write_en,
   output logic                 m_read_en,
   input  logic                 m_done,
   input  logic                 m_busy,
   input  logic [7:0]           m_data_out,
   input  logic [2:0]           m_status
);

   localparam int             IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam bit             TIMEOUT_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST      = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [2:0]     STATUS_TIMEOUT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [IDX_W-1:0]     r_last_idx;
   logic [IDX_W-1:0]     r_owner;
   logic [IDX_W-1:0]     w_sel_idx;
   logic                 w_any_sel;

   logic                 w_accept;
   logic                 w_capture;
   logic                 w_timeout;

   logic                 r_rw;
   logic [NUM_REQ-1:0]   r_grant;
   logic [NUM_REQ-1:0]   r_done;
   logic [6:0]           r_m_chip;
   logic [7:0]           r_m_reg;
   logic [7:0]           r_m_data;
   logic                 r_write_en;
   logic                 r_read_en;
   logic [CNT_W-1:0]     r_cnt;
   logic [7:0]           r_rdata;
   logic [2:0]           r_status;

   // (base + off) modulo NUM_REQ, with off in 1..NUM_REQ.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDX_W'(sum);
   endfunction

   // Round-robin search: the first valid requester after the previous owner.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block can leave it holding a value (which would be a latch).
      w_any_sel = 1'b0;
      w_sel_idx = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         if (!w_any_sel && req_valid[wrap_idx(r_last_idx, off)]) begin
            w_any_sel = 1'b1;
            w_sel_idx = wrap_idx(r_last_idx, off);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values
      // no matter in which order the sequential blocks are evaluated.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic and one-cycle control strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any_sel && !m_busy) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (m_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_RESP;
            end else if (TIMEOUT_EN && (r_cnt == TO_LAST)) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Ownership: latch the winner's fields at grant. Release the bus and move
   // the rotation pointer once the response has been delivered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_idx <= IDX_W'(NUM_REQ - 1);
         r_owner    <= '0;
         r_grant    <= '0;
         r_rw       <= 1'b0;
         r_m_chip   <= '0;
         r_m_reg    <= '0;
         r_m_data   <= '0;
      end else if (w_accept) begin
         r_owner    <= w_sel_idx;
         r_grant    <= NUM_REQ'(1) << w_sel_idx;
         r_rw       <= req_rw[w_sel_idx];
         r_m_chip   <= req_chip_addr[int'(w_sel_idx)*7 +: 7];
         r_m_reg    <= req_reg_addr[int'(w_sel_idx)*8 +: 8];
         r_m_data   <= req_wdata[int'(w_sel_idx)*8 +: 8];
      end else if (r_state == S_RESP) begin
         r_grant    <= '0;
         r_last_idx <= r_owner;
      end
   end

   // Command pulse: exactly one cycle, of one kind, after leaving S_ISSUE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_write_en <= 1'b0;
         r_read_en  <= 1'b0;
      end else begin
         r_write_en <= (r_state == S_ISSUE) && !r_rw;
         r_read_en  <= (r_state == S_ISSUE) &&  r_rw;
      end
   end

   // Watchdog counter: starts from zero on the first S_WAIT cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  r_cnt <= '0;
      else if (r_state == S_ISSUE) r_cnt <= '0;
      else if (r_state == S_WAIT)  r_cnt <= r_cnt + CNT_W'(1);
   end

   // Response: capture the master result (or the timeout code) and pulse
   // req_done to the owner for the single S_RESP cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done   <= '0;
         r_rdata  <= '0;
         r_status <= '0;
      end else begin
         r_done <= (w_capture || w_timeout) ? r_grant : '0;
         if (w_capture) begin
            r_rdata  <= m_data_out;
            r_status <= m_status;
         end else if (w_timeout) begin
            r_rdata  <= '0;
            r_status <= STATUS_TIMEOUT;
         end
      end
   end

   assign grant       = r_grant;
   assign req_done    = r_done;
   assign req_rdata   = r_rdata;
   assign req_status  = r_status;
   assign m_chip_addr = r_m_chip;
   assign m_reg_addr  = r_m_reg;
   assign m_data_in   = r_m_data;
   assign m_write_en  = r_write_en;
   assign m_read_en   = r_read_en;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter. The bench pushes the expected command and
// response of each transaction onto queues as it drives the request. A
// behavioural master pops a command when it sees an enable pulse and answers
// after a per-transaction delay. Each req_done pops and checks a response.

module tb_i2c_bus_arbiter;

   localparam int NUM_REQ = 2;
   localparam int TO_CYC  = 100;

   typedef struct {
      int         idx;
      logic       rw;
      logic [6:0] chip;
      logic [7:0] ra;
      logic [7:0] wd;
      int         delay;   // cycles from enable pulse to m_done; <=0 means never
      logic [7:0] rdata;
      logic [2:0] status;
   } txn_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid, req_rw;
   logic [7*NUM_REQ-1:0] req_chip_addr;
   logic [8*NUM_REQ-1:0] req_reg_addr, req_wdata;
   logic [NUM_REQ-1:0]   grant, req_done;
   logic [7:0]           req_rdata;
   logic [2:0]           req_status;
   logic [6:0]           m_chip_addr;
   logic [7:0]           m_reg_addr, m_data_in;
   logic                 m_write_en, m_read_en;
   logic                 m_done, m_busy;
   logic [7:0]           m_data_out;
   logic [2:0]           m_status;

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   int   done_cnt = 0;
   logic [NUM_REQ-1:0] last_done_vec;
   txn_t cmd_q[$];
   txn_t rsp_q[$];
   int   en_log[$];
   int   done_log[$];

   txn_t mon_e;
   bit   pend_active;
   int   pend_cnt;
   logic [7:0] pend_rdata;
   logic [2:0] pend_status;

   i2c_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO_CYC), .CNT_W(24)) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_rw(req_rw), .req_chip_addr(req_chip_addr),
      .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
      .grant(grant), .req_done(req_done), .req_rdata(req_rdata), .req_status(req_status),
      .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
      .m_write_en(m_write_en), .m_read_en(m_read_en),
      .m_done(m_done), .m_busy(m_busy), .m_data_out(m_data_out), .m_status(m_status)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic txn_t mk(input int idx, input logic rw, input logic [6:0] chip,
                               input logic [7:0] ra, input logic [7:0] wd, input int delay,
                               input logic [7:0] rdata, input logic [2:0] status);
      txn_t t;
      t.idx = idx; t.rw = rw; t.chip = chip; t.ra = ra; t.wd = wd;
      t.delay = delay; t.rdata = rdata; t.status = status;
      return t;
   endfunction

   // Expected response: master result, or rdata=0/status=7 when m_done never comes.
   task automatic push_txn(input txn_t t, input bit exp_rsp);
      txn_t r;
      cmd_q.push_back(t);
      if (exp_rsp) begin
         r = t;
         if (t.delay <= 0) begin
            r.rdata  = 8'h00;
            r.status = 3'b111;
         end
         rsp_q.push_back(r);
      end
   endtask

   task automatic set_req(input txn_t t);
      req_rw[t.idx]                 = t.rw;
      req_chip_addr[t.idx*7 +: 7]   = t.chip;
      req_reg_addr[t.idx*8 +: 8]    = t.ra;
      req_wdata[t.idx*8 +: 8]       = t.wd;
      req_valid[t.idx]              = 1'b1;
   endtask

   task automatic drop_req(input int idx);
      req_valid[idx] = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int start;
      start = done_cnt;
      for (int i = 0; i < limit && done_cnt == start; i++) tick(1);
      check({tag, "_done_seen"}, done_cnt != start, 1);
   endtask

   // Behavioural master plus output monitor, evaluated on the falling edge.
   initial begin
      m_done = 1'b0; m_data_out = 8'h00; m_status = 3'b000;
      pend_active = 1'b0; pend_cnt = 0; pend_rdata = 8'h00; pend_status = 3'b000;
      last_done_vec = '0;
      forever begin
         @(negedge clk);
         m_done = 1'b0;
         if (pend_active) begin
            if (pend_cnt == 0) begin
               m_done      = 1'b1;
               m_data_out  = pend_rdata;
               m_status    = pend_status;
               pend_active = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (m_write_en || m_read_en) begin
            en_log.push_back(cyc);
            check("en_exclusive", {31'd0, m_write_en & m_read_en}, 0);
            check("cmd_expected", cmd_q.size() > 0, 1);
            if (cmd_q.size() > 0) begin
               mon_e = cmd_q.pop_front();
               check("cmd_grant", grant, 1 << mon_e.idx);
               check("cmd_write_en", m_write_en, !mon_e.rw);
               check("cmd_read_en", m_read_en, mon_e.rw);
               check("cmd_chip", m_chip_addr, mon_e.chip);
               check("cmd_reg", m_reg_addr, mon_e.ra);
               if (!mon_e.rw) check("cmd_wdata", m_data_in, mon_e.wd);
               if (mon_e.delay > 0) begin
                  pend_active = 1'b1;
                  pend_cnt    = mon_e.delay - 1;
                  pend_rdata  = mon_e.rdata;
                  pend_status = mon_e.status;
               end
            end
         end
         if (req_done != '0) begin
            done_cnt++;
            last_done_vec = req_done;
            done_log.push_back(cyc);
            check("rsp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
               mon_e = rsp_q.pop_front();
               check("rsp_owner", req_done, 1 << mon_e.idx);
               check("rsp_rdata", req_rdata, mon_e.rdata);
               check("rsp_status", req_status, mon_e.status);
            end
         end
      end
   end

   initial begin
      txn_t t;
      txn_t ct[4];
      int   t0;
      int   nxt[2];
      int   r;

      rst_n = 1'b0;
      req_valid = '0; req_rw = '0; req_chip_addr = '0; req_reg_addr = '0; req_wdata = '0;
      m_busy = 1'b0;

      // Reset state.
      tick(2);
      check("rst_grant", grant, 0);
      check("rst_done", req_done, 0);
      check("rst_en", {m_write_en, m_read_en}, 0);
      check("rst_maddr", {m_chip_addr, m_reg_addr, m_data_in}, 0);
      check("rst_rsp", {req_rdata, req_status}, 0);
      rst_n = 1'b1;
      tick(2);

      // Single write from requester 0, master answers 50 cycles after the pulse.
      t0 = cyc;
      t = mk(0, 1'b0, 7'h39, 8'hD6, 8'hC0, 50, 8'h00, 3'b000);
      push_txn(t, 1'b1);
      set_req(t);
      tick(1);
      check("wr_grant_c1", grant, 2'b01);
      wait_done("wr", 200);
      drop_req(0);
      check("wr_en_latency", en_log[$] - t0, 2);
      check("wr_done_latency", done_log[$] - t0, 53);
      tick(3);

      // Single read from requester 1.
      t = mk(1, 1'b1, 7'h3C, 8'h00, 8'h00, 20, 8'h75, 3'b000);
      push_txn(t, 1'b1);
      set_req(t);
      wait_done("rd", 200);
      drop_req(1);
      tick(3);

      // Contention: both held valid for two transactions each -> 0,1,0,1.
      en_log.delete(); done_log.delete();
      ct[0] = mk(0, 1'b0, 7'h10, 8'h01, 8'h11, 3, 8'h00, 3'b000);
      ct[1] = mk(1, 1'b1, 7'h20, 8'h02, 8'h00, 4, 8'hA1, 3'b000);
      ct[2] = mk(0, 1'b1, 7'h30, 8'h03, 8'h00, 5, 8'hB2, 3'b010);
      ct[3] = mk(1, 1'b0, 7'h40, 8'h04, 8'h44, 6, 8'h00, 3'b000);
      for (int i = 0; i < 4; i++) push_txn(ct[i], 1'b1);
      nxt[0] = 2; nxt[1] = 3;
      set_req(ct[0]);
      set_req(ct[1]);
      for (int n = 0; n < 4; n++) begin
         wait_done("ct", 100);
         r = last_done_vec[1] ? 1 : 0;
         if (nxt[r] < 4) begin
            set_req(ct[nxt[r]]);
            nxt[r] += 2;
         end else begin
            drop_req(r);
         end
      end
      check("ct_en_count", en_log.size(), 4);
      for (int i = 0; i < 3; i++) check("ct_regrant_gap", en_log[i+1] - done_log[i], 3);
      tick(3);

      // Timeout: master never answers; then a normal transaction follows.
      en_log.delete(); done_log.delete();
      t = mk(0, 1'b0, 7'h11, 8'h22, 8'h33, -1, 8'h00, 3'b000);
      push_txn(t, 1'b1);
      set_req(t);
      wait_done("to", 300);
      drop_req(0);
      check("to_latency", done_log[0] - en_log[0], TO_CYC);
      t = mk(1, 1'b0, 7'h12, 8'h34, 8'h56, 10, 8'h5A, 3'b001);
      push_txn(t, 1'b1);
      set_req(t);
      wait_done("after_to", 100);
      drop_req(1);
      tick(3);

      // Busy gating: no grant while m_busy is high.
      m_busy = 1'b1;
      t = mk(0, 1'b0, 7'h21, 8'h43, 8'h65, 5, 8'h77, 3'b000);
      push_txn(t, 1'b1);
      set_req(t);
      tick(20);
      check("busy_no_grant", grant, 0);
      m_busy = 1'b0;
      tick(1);
      check("busy_grant", grant, 2'b01);
      wait_done("busy", 100);
      drop_req(0);
      tick(3);

      // Reset in S_WAIT: outputs clear at once, no req_done, req0 wins afterwards.
      t = mk(0, 1'b0, 7'h55, 8'h66, 8'h77, -1, 8'h00, 3'b000);
      push_txn(t, 1'b0);
      set_req(t);
      tick(6);
      check("rstw_granted", grant, 2'b01);
      rst_n = 1'b0;
      #1;
      check("rstw_grant", grant, 0);
      check("rstw_done", req_done, 0);
      check("rstw_en", {m_write_en, m_read_en}, 0);
      check("rstw_maddr", {m_chip_addr, m_reg_addr, m_data_in}, 0);
      check("rstw_rsp", {req_rdata, req_status}, 0);
      drop_req(0);
      tick(3);
      rst_n = 1'b1;
      tick(1);
      push_txn(mk(0, 1'b1, 7'h61, 8'h10, 8'h00, 4, 8'h66, 3'b000), 1'b1);
      push_txn(mk(1, 1'b0, 7'h62, 8'h20, 8'h99, 4, 8'h00, 3'b000), 1'b1);
      set_req(mk(0, 1'b1, 7'h61, 8'h10, 8'h00, 4, 8'h66, 3'b000));
      set_req(mk(1, 1'b0, 7'h62, 8'h20, 8'h99, 4, 8'h00, 3'b000));
      tick(1);
      check("post_rst_first", grant, 2'b01);
      for (int n = 0; n < 2; n++) begin
         wait_done("post_rst", 100);
         drop_req(last_done_vec[1] ? 1 : 0);
      end
      tick(3);

      check("cmd_q_empty", cmd_q.size(), 0);
      check("rsp_q_empty", rsp_q.size(), 0);
      check("done_total", done_cnt, 11);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
